rv_mini_core: RTL and testbench

// - Minimal RV32I integer core (frontend subset). Fetches instructions over a req/gnt/rvalid instruction bus.
// - Executes integer ALU, branch and jump instructions in order; one instruction in flight, no pipeline.
// - Sits below the SoC controller, which supplies fetch enable and boot address. No data bus; no IRQs.

---
 rtl/rv_mini_core.sv | 128 ++++++++++++
 tb/tb_rv_mini_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mini_core.sv
// rv_mini_core: minimal RV32I integer core, one instruction in flight over a req/gnt/rvalid fetch bus.
// Define CORE_SHIFT_EN to implement SLL/SRL/SRA and their immediate forms; otherwise they execute as NOP.
module rv_mini_core #(
  parameter logic [31:0] REG_RESET_VAL = 32'h0,
  parameter bit          BOOT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  input  logic        instr_gnt_i,
  input  logic        fetch_en_i,
  input  logic [31:0] pc_start_addr_i
);
`ifdef CORE_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_IMM = 7'h13, OP_REG = 7'h33;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EXEC} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic        booted_q, booted_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, imm_b, imm_j, rs1_v, rs2_v, op_b, sra_v, alu_v, wb_v, pc_next;
  logic        f7_ok, alu_ok, lt, ltu, taken, wb_en;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u  = {ir_q[31:12], 12'h0};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_v  = rs1 == 5'd0 ? 32'h0 : rf_q[rs1];
  assign rs2_v  = rs2 == 5'd0 ? 32'h0 : rf_q[rs2];
  assign op_b   = opcode == OP_REG ? rs2_v : imm_i;
  assign shamt  = op_b[4:0];
  assign sra_v  = $signed(rs1_v) >>> shamt;
  assign lt     = $signed(rs1_v) < $signed(rs2_v);
  assign ltu    = rs1_v < rs2_v;
  assign taken  = funct3[2] ? ((funct3[1] ? ltu : lt) ^ funct3[0])
                            : (!funct3[1] && ((rs1_v == rs2_v) ^ funct3[0]));
  // OP-IMM non-shift forms carry immediate bits in funct7; everything else must match exactly
  assign f7_ok  = (opcode == OP_IMM && funct3[1:0] != 2'b01) || funct7 == 7'h00 ||
                  (funct7 == 7'h20 && (funct3 == 3'd5 || (funct3 == 3'd0 && opcode == OP_REG)));
  assign alu_ok = f7_ok && (SHIFT_EN || funct3[1:0] != 2'b01);

  always_comb begin
    alu_v = 32'h0;
    case (funct3)
      3'd0: alu_v = opcode == OP_REG && funct7[5] ? rs1_v - op_b : rs1_v + op_b;
      3'd1: alu_v = rs1_v << shamt;
      3'd2: alu_v = {31'h0, $signed(rs1_v) < $signed(op_b)};
      3'd3: alu_v = {31'h0, rs1_v < op_b};
      3'd4: alu_v = rs1_v ^ op_b;
      3'd5: alu_v = funct7[5] ? sra_v : rs1_v >> shamt;
      3'd6: alu_v = rs1_v | op_b;
      default: alu_v = rs1_v & op_b;
    endcase
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_v    = pc_q + 32'd4;
    pc_next = pc_q + 32'd4;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_v = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_v = pc_q + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; pc_next = pc_q + imm_j; end
      OP_JALR:  if (funct3 == 3'd0) begin wb_en = 1'b1; pc_next = (rs1_v + imm_i) & ~32'h1; end
      OP_BR:    pc_next = taken ? pc_q + imm_b : pc_q + 32'd4;
      OP_IMM, OP_REG: begin wb_en = alu_ok; wb_v = alu_v; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    booted_d = booted_q;
    rf_d     = rf_q;
    case (state_q)
      IDLE: if (fetch_en_i || (BOOT_ON_RESET && !booted_q)) begin
        state_d = FETCH;
        if (!booted_q) begin pc_d = pc_start_addr_i; booted_d = 1'b1; end
      end
      FETCH: state_d = instr_gnt_i ? WAIT : FETCH;
      WAIT: if (instr_rvalid_i) begin ir_d = instr_rdata_i; state_d = EXEC; end
      default: begin
        pc_d = pc_next;
        if (wb_en && rd != 5'd0) rf_d[rd] = wb_v;
        state_d = fetch_en_i ? FETCH : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= 32'h0;
      ir_q     <= 32'h0;
      booted_q <= 1'b0;
      rf_q     <= '{default: REG_RESET_VAL};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      booted_q <= booted_d;
      rf_q     <= rf_d;
    end
  end

  assign instr_req_o  = state_q == FETCH;
  assign instr_addr_o = pc_q;
endmodule

// File: tb/tb_rv_mini_core.sv
// tb_rv_mini_core: fetch addresses are queued as programs are laid out and checked at each grant;
// register results are checked against hand-derived constants once the core parks.
module tb_rv_mini_core;
`ifdef CORE_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h13;
  localparam logic [6:0]  OPI = 7'h13;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_req_o, instr_gnt_i;
  logic        instr_rvalid_i = 1'b0, fetch_en_i = 1'b0;
  logic [31:0] instr_addr_o, instr_rdata_i = 32'h0, pc_start_addr_i = 32'h0;
  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  longint      gt [$];
  int          total = 0, bad = 0, gnt_stall = 0, rv_delay = 0;
  logic [31:0] wp, ap, jp;

  always #5 clk = ~clk;
  assign instr_gnt_i = instr_req_o && gnt_stall == 0;

  rv_mini_core dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i), .instr_gnt_i(instr_gnt_i),
    .fetch_en_i(fetch_en_i), .pc_start_addr_i(pc_start_addr_i)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(int r, logic [31:0] e);
    chk($sformatf("x%0d", r), dut.rf_q[r], e);
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic emit(logic [31:0] ins);
    mem[wp[9:2]] = ins;
    exp_q.push_back(wp);
    wp += 32'd4;
  endtask

  task automatic skip();
    mem[wp[9:2]] = NOP;
    wp += 32'd4;
  endtask

  task automatic run(int budget);
    fetch_en_i = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    fetch_en_i = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // memory responder: combinational gnt after optional stall, rvalid one cycle after gnt plus rv_delay
  initial begin : resp
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (instr_req_o) begin
        if (gnt_stall > 0) begin
          chk("addr_hold", instr_addr_o, exp_q.size() != 0 ? exp_q[0] : 32'hffff_ffff);
          gnt_stall--;
        end
        if (gnt_stall == 0) begin
          a = instr_addr_o;
          chk("fetch_addr", a, exp_q.size() != 0 ? exp_q.pop_front() : 32'hffff_ffff);
          gt.push_back($time);
          @(posedge clk);
          repeat (rv_delay) @(posedge clk);
          #1 instr_rvalid_i = 1'b1;
          instr_rdata_i = mem[a[9:2]];
          @(posedge clk);
          #1 instr_rvalid_i = 1'b0;
          instr_rdata_i = 32'hdead_beef;
        end
      end
    end
  end

  initial begin
    int s0;
    bit down;
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(instr_req_o), 32'h0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk_reg(5, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_req", 32'(instr_req_o), 32'h0);
    end
    // up/down counter in s0 with direction flag s1, t0 = 15
    mem[0]  = enc_r(0, 0, 0, 0, 8);
    mem[1]  = enc_i(15, 0, 0, 5, OPI);
    mem[2]  = enc_i(0, 0, 0, 9, OPI);
    mem[3]  = enc_b(20, 0, 9, 1);
    mem[4]  = enc_i(1, 8, 0, 8, OPI);
    mem[5]  = enc_b(24, 5, 8, 1);
    mem[6]  = enc_i(1, 0, 0, 9, OPI);
    mem[7]  = enc_b(16, 0, 0, 0);
    mem[8]  = enc_i(-1, 8, 0, 8, OPI);
    mem[9]  = enc_b(8, 0, 8, 1);
    mem[10] = enc_i(0, 0, 0, 9, OPI);
    mem[11] = enc_j(-32, 0);
    exp_q = '{32'h00, 32'h04, 32'h08};
    s0 = 0;
    down = 1'b0;
    for (int it = 0; it < 30; it++) begin
      exp_q.push_back(32'h0c);
      if (!down) begin
        exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        s0++;
        if (s0 == 15) begin exp_q.push_back(32'h18); exp_q.push_back(32'h1c); down = 1'b1; end
      end else begin
        exp_q.push_back(32'h20); exp_q.push_back(32'h24);
        s0--;
        if (s0 == 0) begin exp_q.push_back(32'h28); down = 1'b0; end
      end
      exp_q.push_back(32'h2c);
    end
    run(2000);
    chk("spacing0", 32'(gt[1] - gt[0]), 32'd30);
    chk("spacing1", 32'(gt[2] - gt[1]), 32'd30);
    chk_reg(8, 32'h0);
    chk_reg(9, 32'h0);
    chk_reg(5, 32'd15);
    // restart resumes at pc 0x0c; the new boot address must not be reloaded
    pc_start_addr_i = 32'h200;
    mem[3] = enc_j(32'h34, 0);
    exp_q.push_back(32'h0c);
    wp = 32'h40;
    emit(enc_i(-1, 0, 0, 1, OPI)); emit(enc_i(1, 0, 0, 2, OPI));
    emit(enc_b(8, 2, 1, 4)); skip();
    emit(enc_b(8, 2, 1, 6));
    emit(enc_b(8, 1, 2, 5)); skip();
    emit(enc_b(8, 2, 1, 7)); skip();
    emit(enc_b(8, 2, 2, 0)); skip();
    emit(enc_b(8, 2, 2, 1));
    emit(enc_b(8, 2, 1, 0));
    emit(enc_i(5, 0, 0, 0, OPI)); emit(enc_i(7, 0, 0, 31, OPI));
    emit(enc_u(32'h12345, 10, 7'h37)); emit(enc_i(32'h678, 10, 0, 11, OPI));
    emit(enc_r(32, 1, 2, 0, 12)); emit(enc_r(0, 1, 11, 7, 13));
    emit(enc_r(0, 1, 11, 4, 14)); emit(enc_r(0, 10, 2, 6, 15));
    emit(enc_r(0, 2, 1, 2, 16)); emit(enc_r(0, 2, 1, 3, 17));
    emit(enc_i(0, 1, 2, 18, OPI)); emit(enc_i(-1, 2, 3, 19, OPI));
    emit(enc_i(255, 11, 7, 20, OPI)); emit(enc_i(-2048, 0, 6, 21, OPI));
    emit(enc_i(-1, 11, 4, 22, OPI));
    ap = wp;
    emit(enc_u(1, 23, 7'h17));
    emit(32'h00b0_2023); emit(enc_i(0, 0, 2, 24, 7'h03)); emit(32'h73);
    emit(enc_r(1, 2, 1, 0, 6));
    emit(enc_u(32'h80000, 27, 7'h37));
    emit(enc_i(32'h404, 27, 5, 26, OPI)); emit(enc_i(4, 27, 5, 28, OPI));
    emit(enc_i(4, 11, 1, 25, OPI)); emit(enc_r(32, 2, 27, 5, 4));
    emit(enc_r(0, 11, 11, 0, 29));
    jp = wp;
    emit(enc_j(8, 30)); skip();
    emit(NOP);
    run(1000);
    chk_reg(1, 32'hffff_ffff); chk_reg(2, 32'h1); chk_reg(31, 32'd7);
    chk_reg(10, 32'h1234_5000); chk_reg(11, 32'h1234_5678); chk_reg(12, 32'h2);
    chk_reg(13, 32'h1234_5678); chk_reg(14, 32'hedcb_a987); chk_reg(15, 32'h1234_5001);
    chk_reg(16, 32'h1); chk_reg(17, 32'h0); chk_reg(18, 32'h1); chk_reg(19, 32'h1);
    chk_reg(20, 32'h78); chk_reg(21, 32'hffff_f800); chk_reg(22, 32'hedcb_a987);
    chk_reg(23, ap + 32'h1000); chk_reg(24, 32'h0); chk_reg(6, 32'h0);
    chk_reg(27, 32'h8000_0000); chk_reg(29, 32'h2468_acf0); chk_reg(30, jp + 32'd4);
    chk_reg(26, SH ? 32'hf800_0000 : 32'h0); chk_reg(28, SH ? 32'h0800_0000 : 32'h0);
    chk_reg(25, SH ? 32'h2345_6780 : 32'h0); chk_reg(4, SH ? 32'hc000_0000 : 32'h0);
    // stalled bus, fetch_en dropped right after the grant
    emit(enc_i(1, 5, 0, 5, OPI));
    gnt_stall = 4;
    rv_delay = 2;
    run(200);
    gnt_stall = 0;
    rv_delay = 0;
    chk_reg(5, 32'd16);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("parked_req", 32'(instr_req_o), 32'h0);
    end
    // JALR to a misaligned target, fetched unchecked
    mem[1] = NOP;
    ap = wp;
    emit(enc_i(6, 2, 0, 3, 7'h67));
    exp_q.push_back(32'h06);
    run(200);
    chk_reg(3, ap + 32'd4);
    chk("final_req", 32'(instr_req_o), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
